// File: rtl/lcd_ctrl_param.sv
// HD44780-class character-LCD controller: power-up delay, init sequence and
// enable-strobe timing for an 8-bit or 4-bit (nibble) LCD bus.
module lcd_ctrl_param #(
    parameter int unsigned CLK_PER_US = 25,
    parameter bit          BUS4       = 1'b0,
    parameter int unsigned PWRUP_US   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cfg,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);

    localparam int unsigned C        = CLK_PER_US;
    localparam int unsigned PwrupCyc = PWRUP_US * C;
    localparam int unsigned LongCyc  = 2027 * C;
    localparam int unsigned MaxCnt   = (PwrupCyc > LongCyc) ? PwrupCyc : LongCyc;
    localparam int unsigned CntW     = $clog2(MaxCnt + 1);

    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic [1:0] {StPwrup, StInit, StIdle, StXfer} state_e;

    // Step 0 is the lone 0x2 nibble that switches the LCD into 4-bit mode.
    localparam logic [2:0] FirstStep = BUS4 ? 3'd0 : 3'd1;
    localparam logic [2:0] LastStep  = 3'd4;

    function automatic logic e_at(input cnt_t k, input logic two);
        e_at = (k >= cnt_t'(C) && k < cnt_t'(14 * C)) ||
               (two && k >= cnt_t'(28 * C) && k < cnt_t'(41 * C));
    endfunction

    function automatic logic is_long(input logic r_s, input logic r_w, input logic [7:0] b);
        is_long = !r_s && !r_w && (b[7:2] == 6'd0) && (b != 8'd0);
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] step, input logic [6:0] c);
        case (step)
            3'd0:    init_byte = 8'h20;
            3'd1:    init_byte = {3'b001, !BUS4, c[6], c[5], 2'b00};
            3'd2:    init_byte = {5'b00001, c[4:2]};
            3'd3:    init_byte = 8'h01;
            default: init_byte = {6'b000001, c[1:0]};
        endcase
    endfunction

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] step_q, step_d;
    logic [3:0] lo_q, lo_d;
    logic       single_q, single_d;
    logic       long_q, long_d;
    logic       rs_q, rs_d;
    logic       rw_q, rw_d;
    logic [7:0] data_q, data_d;
    logic       e_q, e_d;
    logic       init_done_q, init_done_d;

    logic       two_q;
    cnt_t       win_last;
    logic       start;
    logic [7:0] start_byte;
    logic       start_rs;
    logic       start_rw;
    logic       start_single;

    assign two_q = BUS4 && !single_q;

    always_comb begin
        if (long_q) begin
            win_last = two_q ? cnt_t'(2027 * C - 1) : cnt_t'(2000 * C - 1);
        end else begin
            win_last = two_q ? cnt_t'(77 * C - 1) : cnt_t'(50 * C - 1);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        lo_d         = lo_q;
        single_d     = single_q;
        long_d       = long_q;
        rs_d         = rs_q;
        rw_d         = rw_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        start        = 1'b0;
        start_byte   = 8'h00;
        start_rs     = 1'b0;
        start_rw     = 1'b0;
        start_single = 1'b0;

        case (state_q)
            StPwrup: begin
                if (cnt_q == cnt_t'(PwrupCyc - 1)) begin
                    state_d      = StInit;
                    step_d       = FirstStep;
                    start        = 1'b1;
                    start_byte   = init_byte(FirstStep, cfg);
                    start_single = BUS4;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StInit: begin
                if (cnt_q == win_last) begin
                    if (step_q == LastStep) begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end else begin
                        step_d     = step_q + 3'd1;
                        start      = 1'b1;
                        start_byte = init_byte(step_q + 3'd1, cfg);
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StIdle: begin
                if (cmd_valid) begin
                    state_d    = StXfer;
                    start      = 1'b1;
                    start_byte = cmd_data;
                    start_rs   = cmd_rs;
                    start_rw   = cmd_rw;
                end
            end
            StXfer: begin
                if (cnt_q == win_last) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = StPwrup;
        endcase

        if (start) begin
            cnt_d    = '0;
            lo_d     = start_byte[3:0];
            rs_d     = start_rs;
            rw_d     = start_rw;
            single_d = start_single;
            long_d   = is_long(start_rs, start_rw, start_byte);
            data_d   = BUS4 ? {start_byte[7:4], 4'b0000} : start_byte;
        end

        // Second nibble goes onto the bus exactly at k = 27C.
        if ((state_q == StInit || state_q == StXfer) && two_q &&
            cnt_q == cnt_t'(27 * C - 1)) begin
            data_d = {lo_q, 4'b0000};
        end

        e_d = (state_d == StInit || state_d == StXfer) && e_at(cnt_d, BUS4 && !single_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPwrup;
            cnt_q       <= '0;
            step_q      <= 3'd0;
            lo_q        <= 4'd0;
            single_q    <= 1'b0;
            long_q      <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            data_q      <= 8'd0;
            e_q         <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            lo_q        <= lo_d;
            single_q    <= single_d;
            long_q      <= long_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            data_q      <= data_d;
            e_q         <= e_d;
            init_done_q <= init_done_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = !cmd_ready;
    assign e         = e_q;
    assign rs        = rs_q;
    assign rw        = rw_q;
    assign lcd_data  = data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: one 8-bit and one 4-bit instance
// compared cycle by cycle against a transfer-level pin model.
module tb_lcd_ctrl_param;

    localparam int C  = 2;
    localparam int PW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n8, rst_n4;
    logic [6:0] cfg8, cfg4;
    logic       v8, rsi8, rwi8, v4, rsi4, rwi4;
    logic [7:0] di8, di4;
    logic       rdy8, e8, rs8, rw8, busy8, done8;
    logic       rdy4, e4, rs4, rw4, busy4, done4;
    logic [7:0] lcd8, lcd4;

    lcd_ctrl_param #(.CLK_PER_US(C), .BUS4(1'b0), .PWRUP_US(PW)) u_dut8 (
        .clk(clk), .rst_n(rst_n8), .cfg(cfg8), .cmd_valid(v8), .cmd_rs(rsi8),
        .cmd_rw(rwi8), .cmd_data(di8), .cmd_ready(rdy8), .e(e8), .rs(rs8), .rw(rw8),
        .lcd_data(lcd8), .busy(busy8), .init_done(done8)
    );

    lcd_ctrl_param #(.CLK_PER_US(C), .BUS4(1'b1), .PWRUP_US(PW)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .cfg(cfg4), .cmd_valid(v4), .cmd_rs(rsi4),
        .cmd_rw(rwi4), .cmd_data(di4), .cmd_ready(rdy4), .e(e4), .rs(rs4), .rw(rw4),
        .lcd_data(lcd4), .busy(busy4), .init_done(done4)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] last_d  [2];
    logic       last_rs [2];
    logic       last_rw [2];

    // Packed pin view: {busy, init_done, cmd_ready, e, rs, rw, lcd_data}.
    function automatic logic [13:0] obs(input bit bus4);
        if (bus4) return {busy4, done4, rdy4, e4, rs4, rw4, lcd4};
        return {busy8, done8, rdy8, e8, rs8, rw8, lcd8};
    endfunction

    function automatic logic [13:0] xfer_pins(input int k, input logic [7:0] b, input logic r_s,
                                             input logic r_w, input bit bus4, input bit single,
                                             input logic done);
        int kk;
        bit second;
        logic ee;
        logic [7:0] d;
        second = bus4 && !single && (k >= 27 * C);
        kk = second ? k - 27 * C : k;
        ee = (kk >= C) && (kk < 14 * C);
        if (!bus4) d = b;
        else if (second) d = {b[3:0], 4'h0};
        else d = {b[7:4], 4'h0};
        return {1'b1, done, 1'b0, ee, r_s, r_w, d};
    endfunction

    function automatic logic [13:0] idle_pins(input logic [7:0] d, input logic r_s,
                                             input logic r_w);
        return {1'b0, 1'b1, 1'b1, 1'b0, r_s, r_w, d};
    endfunction

    function automatic int win(input logic [7:0] b, input logic r_s, input logic r_w,
                               input bit bus4, input bit single);
        int w;
        w = (bus4 && !single) ? 77 * C : 50 * C;
        if (!r_s && !r_w && b != 8'h00 && b < 8'h04) w += 1950 * C;
        return w;
    endfunction

    task automatic drive(input bit bus4, input logic v, input logic r_s, input logic r_w,
                         input logic [7:0] d);
        if (bus4) begin
            v4 = v; rsi4 = r_s; rwi4 = r_w; di4 = d;
        end else begin
            v8 = v; rsi8 = r_s; rwi8 = r_w; di8 = d;
        end
    endtask

    task automatic test_reset();
        rst_n8 = 1'b0; rst_n4 = 1'b0;
        cfg8 = 7'h7F; cfg4 = 7'($urandom);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (obs(s[0]) !== 14'h2000) begin
                errors++;
                $display("FAIL reset_state bus4=%0d: got %h want %h", s, obs(s[0]), 14'h2000);
            end
        end
    endtask

    task automatic test_init8();
        logic [7:0] seq [4];
        logic [13:0] exp;
        int w;
        seq = '{8'h3C, 8'h0F, 8'h01, 8'h07};
        cfg8 = 7'h7F;
        rst_n8 = 1'b1;
        for (int i = 0; i < PW * C; i++) begin
            checks++;
            if (obs(1'b0) !== 14'h2000) begin
                errors++;
                $display("FAIL pwrup8 cycle %0d: got %h want %h", i, obs(1'b0), 14'h2000);
            end
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            @(negedge clk);
        end
        for (int s = 0; s < 4; s++) begin
            w = win(seq[s], 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < w; k++) begin
                exp = xfer_pins(k, seq[s], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                checks++;
                if (obs(1'b0) !== exp) begin
                    errors++;
                    $display("FAIL init8 step %0d k=%0d: got %h want %h", s, k, obs(1'b0), exp);
                end
                if (s == 3 && k == w - 1) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                else drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                @(negedge clk);
            end
        end
        checks++;
        if (obs(1'b0) !== idle_pins(8'h07, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL init8_done: got %h want %h", obs(1'b0), idle_pins(8'h07, 1'b0, 1'b0));
        end
        last_d[0] = 8'h07; last_rs[0] = 1'b0; last_rw[0] = 1'b0;
    endtask

    task automatic test_init4();
        logic [7:0] b;
        logic [13:0] exp;
        bit single;
        int w;
        rst_n4 = 1'b1;
        for (int i = 0; i < PW * C; i++) begin
            checks++;
            if (obs(1'b1) !== 14'h2000) begin
                errors++;
                $display("FAIL pwrup4 cycle %0d: got %h want %h", i, obs(1'b1), 14'h2000);
            end
            @(negedge clk);
        end
        for (int s = 0; s < 5; s++) begin
            single = (s == 0);
            case (s)
                0:       b = 8'h20;
                1:       b = {4'b0010, cfg4[6], cfg4[5], 2'b00};
                2:       b = {5'b00001, cfg4[4:2]};
                3:       b = 8'h01;
                default: b = {6'b000001, cfg4[1:0]};
            endcase
            w = win(b, 1'b0, 1'b0, 1'b1, single);
            for (int k = 0; k < w; k++) begin
                exp = xfer_pins(k, b, 1'b0, 1'b0, 1'b1, single, 1'b0);
                checks++;
                if (obs(1'b1) !== exp) begin
                    errors++;
                    $display("FAIL init4 step %0d k=%0d: got %h want %h", s, k, obs(1'b1), exp);
                end
                if (k == 5) cfg4 = 7'($urandom);
                if (s == 4 && k == w - 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                else drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                @(negedge clk);
            end
        end
        exp = idle_pins({b[3:0], 4'h0}, 1'b0, 1'b0);
        checks++;
        if (obs(1'b1) !== exp) begin
            errors++;
            $display("FAIL init4_done: got %h want %h", obs(1'b1), exp);
        end
        last_d[1] = {b[3:0], 4'h0}; last_rs[1] = 1'b0; last_rw[1] = 1'b0;
    endtask

    task automatic test_write8();
        logic [13:0] exp;
        int w;
        int ehigh;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h41);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        w = win(8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        ehigh = 0;
        for (int k = 0; k < w; k++) begin
            exp = xfer_pins(k, 8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs(1'b0) !== exp) begin
                errors++;
                $display("FAIL write8 k=%0d: got %h want %h", k, obs(1'b0), exp);
            end
            if (e8 === 1'b1) ehigh++;
            @(negedge clk);
        end
        checks++;
        if (ehigh != 26) begin
            errors++;
            $display("FAIL write8_e_width: got %0d want 26", ehigh);
        end
        checks++;
        if (obs(1'b0) !== idle_pins(8'h41, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL write8_ready: got %h want %h", obs(1'b0), idle_pins(8'h41, 1'b1, 1'b0));
        end
        last_d[0] = 8'h41; last_rs[0] = 1'b1; last_rw[0] = 1'b0;
    endtask

    task automatic test_nibble4();
        logic [13:0] exp;
        int w;
        int pulses;
        logic prev_e;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        w = win(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        prev_e = 1'b0;
        for (int k = 0; k < w; k++) begin
            exp = xfer_pins(k, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs(1'b1) !== exp) begin
                errors++;
                $display("FAIL nibble4 k=%0d: got %h want %h", k, obs(1'b1), exp);
            end
            if (e4 === 1'b1 && prev_e !== 1'b1) pulses++;
            prev_e = e4;
            @(negedge clk);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL nibble4_pulses: got %0d want 2", pulses);
        end
        checks++;
        if (obs(1'b1) !== idle_pins(8'h50, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL nibble4_idle: got %h want %h", obs(1'b1), idle_pins(8'h50, 1'b1, 1'b0));
        end
        last_d[1] = 8'h50; last_rs[1] = 1'b1; last_rw[1] = 1'b0;
    endtask

    task automatic test_long_short();
        logic [7:0] tdat [8];
        logic       trs  [8];
        bit         tb4  [8];
        int         texp [8];
        logic [13:0] o;
        int cnt;
        tdat = '{8'h02, 8'h80, 8'h03, 8'h01, 8'h00, 8'h04, 8'h01, 8'h80};
        trs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tb4  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        texp = '{4000, 100, 4000, 100, 100, 100, 4054, 154};
        for (int i = 0; i < 8; i++) begin
            drive(tb4[i], 1'b1, trs[i], 1'b0, tdat[i]);
            @(negedge clk);
            drive(tb4[i], 1'b0, 1'b0, 1'b0, 8'h00);
            cnt = 0;
            o = obs(tb4[i]);
            while (o[11] !== 1'b1 && cnt < 6000) begin
                cnt++;
                @(negedge clk);
                o = obs(tb4[i]);
            end
            checks++;
            if (cnt != texp[i]) begin
                errors++;
                $display("FAIL window bus4=%0d data=%h rs=%0d: got %0d want %0d",
                         tb4[i], tdat[i], trs[i], cnt, texp[i]);
            end
            last_d[int'(tb4[i])]  = tb4[i] ? {tdat[i][3:0], 4'h0} : tdat[i];
            last_rs[int'(tb4[i])] = trs[i];
            last_rw[int'(tb4[i])] = 1'b0;
        end
    endtask

    task automatic test_random();
        bit b4;
        int sel;
        logic [7:0] d;
        logic r_s, r_w;
        logic [13:0] exp;
        int w, gap;
        for (int n = 0; n < 16; n++) begin
            b4 = 1'($urandom_range(0, 1));
            sel = b4 ? 1 : 0;
            d = 8'($urandom);
            r_s = 1'($urandom);
            r_w = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                exp = idle_pins(last_d[sel], last_rs[sel], last_rw[sel]);
                checks++;
                if (obs(b4) !== exp) begin
                    errors++;
                    $display("FAIL idle_hold bus4=%0d: got %h want %h", sel, obs(b4), exp);
                end
                @(negedge clk);
            end
            drive(b4, 1'b1, r_s, r_w, d);
            @(negedge clk);
            w = win(d, r_s, r_w, b4, 1'b0);
            for (int k = 0; k < w; k++) begin
                exp = xfer_pins(k, d, r_s, r_w, b4, 1'b0, 1'b1);
                checks++;
                if (obs(b4) !== exp) begin
                    errors++;
                    $display("FAIL rand_xfer bus4=%0d data=%h k=%0d: got %h want %h",
                             sel, d, k, obs(b4), exp);
                end
                if (k < w - 1) drive(b4, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
                else drive(b4, 1'b0, 1'b0, 1'b0, 8'h00);
                @(negedge clk);
            end
            exp = xfer_pins(w - 1, d, r_s, r_w, b4, 1'b0, 1'b1);
            last_d[sel] = exp[7:0]; last_rs[sel] = r_s; last_rw[sel] = r_w;
            exp = idle_pins(last_d[sel], r_s, r_w);
            checks++;
            if (obs(b4) !== exp) begin
                errors++;
                $display("FAIL rand_idle bus4=%0d: got %h want %h", sel, obs(b4), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [3];
        logic [13:0] exp;
        int w;
        for (int i = 0; i < 3; i++) q[i] = 8'($urandom);
        drive(1'b0, 1'b1, 1'b1, 1'b0, q[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) drive(1'b0, 1'b1, 1'b1, 1'b0, q[i + 1]);
            else drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            w = win(q[i], 1'b1, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < w; k++) begin
                exp = xfer_pins(k, q[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                checks++;
                if (obs(1'b0) !== exp) begin
                    errors++;
                    $display("FAIL b2b cmd %0d k=%0d: got %h want %h", i, k, obs(1'b0), exp);
                end
                @(negedge clk);
            end
            checks++;
            if (obs(1'b0) !== idle_pins(q[i], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL b2b_gap cmd %0d: got %h want %h", i, obs(1'b0),
                         idle_pins(q[i], 1'b1, 1'b0));
            end
        end
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            checks++;
            if (obs(1'b0) !== idle_pins(q[2], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL b2b_extra cycle %0d: got %h want %h", g, obs(1'b0),
                         idle_pins(q[2], 1'b1, 1'b0));
            end
        end
        last_d[0] = q[2]; last_rs[0] = 1'b1; last_rw[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [13:0] exp;
        d = 8'($urandom_range(32, 255));
        drive(1'b0, 1'b1, 1'b1, 1'b0, d);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 10; k++) begin
            exp = xfer_pins(k, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs(1'b0) !== exp) begin
                errors++;
                $display("FAIL mid_xfer k=%0d: got %h want %h", k, obs(1'b0), exp);
            end
            @(negedge clk);
        end
        rst_n8 = 1'b0;
        #1;
        checks++;
        if (obs(1'b0) !== 14'h2000) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs(1'b0), 14'h2000);
        end
        @(negedge clk);
        checks++;
        if (obs(1'b0) !== 14'h2000) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs(1'b0), 14'h2000);
        end
        test_init8();
    endtask

    initial begin
        test_reset();
        test_init8();
        test_init4();
        test_write8();
        test_nibble4();
        test_long_short();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
